// File: rtl/rv_dm_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state and load-owner encodings.
package rv_dm_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE      = 1'b0,
        ARB_WAIT_DATA = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_CORE = 1'b0,
        ARB_OWN_DBG  = 1'b1
    } arb_owner_t;

    localparam int STARVE_W = 8;
    localparam int TMO_W    = 16;

endpackage

// File: rtl/rv_dm_arbiter.sv
// Shares the data-memory port between the core execute stage and the debug port,
// tracks one outstanding load and returns its data (or a timeout error) to the owner.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ARB_IDLE      | combinational grant each cycle; stores complete on accept
// ARB_WAIT_DATA | one load outstanding; no grants until data or timeout
module rv_dm_arbiter
    import rv_dm_arbiter_pkg::*;
#(
    parameter int unsigned DBG_MAX_WAIT   = 15,
    parameter int unsigned RVALID_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_data_i,
    input  logic [3:0]  c_sel_i,
    input  logic        c_load_i,
    input  logic        c_store_i,
    output logic        c_ready_o,
    output logic [31:0] c_rdata_o,
    output logic        c_rvalid_o,

    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_data_i,
    input  logic [3:0]  dbg_sel_i,
    input  logic        dbg_load_i,
    input  logic        dbg_store_i,
    output logic        dbg_ready_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_rvalid_o,

    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_sel_o,
    output logic        m_load_o,
    output logic        m_store_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_rdata_i,
    input  logic        m_rvalid_i,

    output logic        busy_o,
    output logic        err_o
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(DBG_MAX_WAIT);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(RVALID_TIMEOUT - 1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    arb_owner_t          r_owner;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [31:0]         r_c_rdata;
    logic [31:0]         r_dbg_rdata;
    logic                r_c_rvalid;
    logic                r_dbg_rvalid;
    logic                r_err;

    logic w_c_req;
    logic w_dbg_req;
    logic w_grant_core;
    logic w_grant_dbg;
    logic w_load_accept;
    logic w_dbg_accept;
    logic w_tmo_hit;

    assign w_c_req   = c_load_i | c_store_i;
    assign w_dbg_req = dbg_load_i | dbg_store_i;
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

    // Grant mux; gating on rst_n_i keeps m_load_o/m_store_o low throughout reset.
    always_comb begin
        w_grant_core  = 1'b0;
        w_grant_dbg   = 1'b0;
        m_addr_o      = c_addr_i;
        m_data_o      = c_data_i;
        m_sel_o       = c_sel_i;
        m_load_o      = 1'b0;
        m_store_o     = 1'b0;
        c_ready_o     = 1'b0;
        dbg_ready_o   = 1'b0;
        if (rst_n_i && (r_state == ARB_IDLE)) begin
            w_grant_dbg  = w_dbg_req && (!w_c_req || (r_starve_cnt == STARVE_MAX));
            w_grant_core = w_c_req && !w_grant_dbg;
        end
        if (w_grant_dbg) begin
            m_addr_o    = dbg_addr_i;
            m_data_o    = dbg_data_i;
            m_sel_o     = dbg_sel_i;
            m_load_o    = dbg_load_i;
            m_store_o   = dbg_store_i & ~dbg_load_i;
            dbg_ready_o = m_ready_i;
        end else if (w_grant_core) begin
            m_load_o    = c_load_i;
            m_store_o   = c_store_i & ~c_load_i;
            c_ready_o   = m_ready_i;
        end
    end

    assign w_load_accept = m_load_o & m_ready_i;
    assign w_dbg_accept  = w_grant_dbg & m_ready_i;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:      if (w_load_accept) w_next_state = ARB_WAIT_DATA;
            ARB_WAIT_DATA: if (m_rvalid_i || w_tmo_hit) w_next_state = ARB_IDLE;
            default:       w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ARB_IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_owner      <= ARB_OWN_CORE;
            r_tmo_cnt    <= '0;
            r_c_rdata    <= '0;
            r_dbg_rdata  <= '0;
            r_c_rvalid   <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_c_rvalid   <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_load_accept) begin
                        r_owner   <= w_grant_dbg ? ARB_OWN_DBG : ARB_OWN_CORE;
                        r_tmo_cnt <= '0;
                    end
                end
                ARB_WAIT_DATA: begin
                    if (m_rvalid_i || w_tmo_hit) begin
                        // A timed-out load returns zero data alongside the error pulse.
                        if (r_owner == ARB_OWN_DBG) begin
                            r_dbg_rdata  <= m_rvalid_i ? m_rdata_i : '0;
                            r_dbg_rvalid <= 1'b1;
                        end else begin
                            r_c_rdata    <= m_rvalid_i ? m_rdata_i : '0;
                            r_c_rvalid   <= 1'b1;
                        end
                        r_err <= ~m_rvalid_i;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_starve_cnt <= '0;
        end else if (w_dbg_req && !w_dbg_accept) begin
            if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign c_rdata_o    = r_c_rdata;
    assign c_rvalid_o   = r_c_rvalid;
    assign dbg_rdata_o  = r_dbg_rdata;
    assign dbg_rvalid_o = r_dbg_rvalid;
    assign err_o        = r_err;
    assign busy_o       = (r_state == ARB_WAIT_DATA);

endmodule

// File: tb/tb_rv_dm_arbiter.sv
// Directed scenarios followed by random traffic, each cycle checked against a
// transaction-level model of the arbiter kept in the bench.
module tb_rv_dm_arbiter;

    localparam int MAXW = 15;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] c_addr, c_data, dbg_addr, dbg_data, m_rdata;
    logic [3:0]  c_sel, dbg_sel;
    logic        c_load, c_store, dbg_load, dbg_store, m_ready, m_rvalid;
    logic        c_ready, c_rvalid, dbg_ready, dbg_rvalid;
    logic [31:0] c_rdata, dbg_rdata, m_addr, m_data;
    logic [3:0]  m_sel;
    logic        m_load, m_store, busy, err;

    always #5 clk = ~clk;

    rv_dm_arbiter #(.DBG_MAX_WAIT(MAXW), .RVALID_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .c_addr_i(c_addr), .c_data_i(c_data), .c_sel_i(c_sel),
        .c_load_i(c_load), .c_store_i(c_store), .c_ready_o(c_ready),
        .c_rdata_o(c_rdata), .c_rvalid_o(c_rvalid),
        .dbg_addr_i(dbg_addr), .dbg_data_i(dbg_data), .dbg_sel_i(dbg_sel),
        .dbg_load_i(dbg_load), .dbg_store_i(dbg_store), .dbg_ready_o(dbg_ready),
        .dbg_rdata_o(dbg_rdata), .dbg_rvalid_o(dbg_rvalid),
        .m_addr_o(m_addr), .m_data_o(m_data), .m_sel_o(m_sel),
        .m_load_o(m_load), .m_store_o(m_store), .m_ready_i(m_ready),
        .m_rdata_i(m_rdata), .m_rvalid_i(m_rvalid),
        .busy_o(busy), .err_o(err)
    );

    int checks   = 0;
    int failures = 0;

    // Model: a load is "outstanding" for some owner; waited counts data-less wait cycles.
    bit          md_outstanding;
    bit          md_owner_dbg;
    int          md_starve;
    int          md_waited;
    bit          ex_c_rv, ex_d_rv, ex_err;
    logic [31:0] ex_c_rd, ex_d_rd;
    bit          seen_c_ready, seen_d_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        md_outstanding = 0;
        md_owner_dbg   = 0;
        md_starve      = 0;
        md_waited      = 0;
        ex_c_rv = 0; ex_d_rv = 0; ex_err = 0;
        ex_c_rd = '0; ex_d_rd = '0;
    endtask

    task automatic clear_inputs();
        c_load = 0; c_store = 0; dbg_load = 0; dbg_store = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // One clock: check everything at the negedge, advance the model at the posedge.
    task automatic step(input string tag);
        bit creq, dreq, to_dbg, to_core, exp_ld, exp_st, accepted, rv;
        logic [31:0] rd, exp_addr, exp_data;
        logic [3:0]  exp_sel;
        @(negedge clk);
        creq    = c_load | c_store;
        dreq    = dbg_load | dbg_store;
        to_dbg  = !md_outstanding && dreq && (!creq || md_starve == MAXW);
        to_core = !md_outstanding && creq && !to_dbg;
        exp_ld  = to_dbg ? dbg_load : (to_core ? c_load : 1'b0);
        exp_st  = to_dbg ? (dbg_store && !dbg_load) : (to_core ? (c_store && !c_load) : 1'b0);
        exp_addr = to_dbg ? dbg_addr : c_addr;
        exp_data = to_dbg ? dbg_data : c_data;
        exp_sel  = to_dbg ? dbg_sel  : c_sel;
        accepted = (exp_ld || exp_st) && m_ready;
        rv = m_rvalid;
        rd = m_rdata;
        seen_c_ready = c_ready;
        seen_d_ready = dbg_ready;
        chk({tag, ":c_ready"},    c_ready,    to_core && m_ready);
        chk({tag, ":dbg_ready"},  dbg_ready,  to_dbg && m_ready);
        chk({tag, ":m_load"},     m_load,     exp_ld);
        chk({tag, ":m_store"},    m_store,    exp_st);
        chk({tag, ":busy"},       busy,       md_outstanding);
        chk({tag, ":c_rvalid"},   c_rvalid,   ex_c_rv);
        chk({tag, ":dbg_rvalid"}, dbg_rvalid, ex_d_rv);
        chk({tag, ":err"},        err,        ex_err);
        chk({tag, ":c_rdata"},    c_rdata,    ex_c_rd);
        chk({tag, ":dbg_rdata"},  dbg_rdata,  ex_d_rd);
        if (to_dbg || to_core) begin
            chk({tag, ":m_addr"}, m_addr, exp_addr);
            chk({tag, ":m_data"}, m_data, exp_data);
            chk({tag, ":m_sel"},  m_sel,  exp_sel);
        end
        @(posedge clk);
        ex_c_rv = 0; ex_d_rv = 0; ex_err = 0;
        if (md_outstanding) begin
            if (rv || md_waited + 1 == TMO) begin
                if (md_owner_dbg) begin ex_d_rd = rv ? rd : 32'h0; ex_d_rv = 1; end
                else              begin ex_c_rd = rv ? rd : 32'h0; ex_c_rv = 1; end
                ex_err = !rv;
                md_outstanding = 0;
            end else begin
                md_waited++;
            end
        end else if (accepted && exp_ld) begin
            md_outstanding = 1;
            md_owner_dbg   = to_dbg;
            md_waited      = 0;
        end
        if (dreq && !(to_dbg && accepted)) md_starve = (md_starve < MAXW) ? md_starve + 1 : MAXW;
        else                               md_starve = 0;
        #1;
    endtask

    initial begin
        int n;
        clear_inputs();
        c_addr = '0; c_data = '0; c_sel = '0; dbg_addr = '0; dbg_data = '0; dbg_sel = '0;
        reset_model();
        rst_n = 0;
        c_load = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst:m_load", m_load, 0);
        chk("rst:busy", busy, 0);
        chk("rst:c_rvalid", c_rvalid, 0);
        chk("rst:err", err, 0);
        chk("rst:c_rdata", c_rdata, 0);
        c_load = 0;
        rst_n = 1;

        // Core store completes in the accept cycle
        c_store = 1; c_addr = 32'h100; c_data = 32'hDEADBEEF; c_sel = 4'hF; m_ready = 1;
        step("t1");
        chk("t1:seen_c_ready", seen_c_ready, 1);
        c_store = 0;
        step("t1_idle");

        // Core load, data three cycles after accept
        c_load = 1; c_addr = 32'h200;
        step("t2_acc");
        c_load = 0;
        step("t2_w1");
        step("t2_w2");
        m_rvalid = 1; m_rdata = 32'h12345678;
        step("t2_w3");
        m_rvalid = 0;
        chk("t2:c_rvalid_pulse", c_rvalid, 1);
        chk("t2:c_rdata_val", c_rdata, 32'h12345678);
        chk("t2:dbg_rvalid_quiet", dbg_rvalid, 0);
        step("t2_done");

        // Debug starved by back-to-back core stores
        c_store = 1; c_addr = 32'h104; dbg_load = 1; dbg_addr = 32'h300; dbg_sel = 4'h3;
        n = 0;
        do begin
            n++;
            step("t3");
        end while (!seen_d_ready && n < 40);
        chk("t3:grant_cycle", n, 16);
        c_store = 0; dbg_load = 0;
        step("t3_w1");
        m_rvalid = 1; m_rdata = 32'hCAFEF00D;
        step("t3_w2");
        m_rvalid = 0;
        chk("t3:dbg_rdata_val", dbg_rdata, 32'hCAFEF00D);

        // Simultaneous requests with an empty starvation counter
        c_store = 1; dbg_store = 1; dbg_data = 32'h55AA55AA;
        step("t4");
        chk("t4:core_won", seen_c_ready, 1);
        chk("t4:dbg_lost", seen_d_ready, 0);
        c_store = 0;
        step("t4_dbg");
        dbg_store = 0;

        // Debug load with no data returned: timeout
        dbg_load = 1; dbg_addr = 32'h400;
        step("t5_acc");
        dbg_load = 0;
        for (int i = 0; i < TMO; i++) step("t5_wait");
        chk("t5:dbg_rvalid_pulse", dbg_rvalid, 1);
        chk("t5:err_pulse", err, 1);
        chk("t5:dbg_rdata_zero", dbg_rdata, 0);
        m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
        step("t5_late");
        m_rvalid = 0;
        chk("t5:late_ignored", dbg_rvalid, 0);
        step("t5_idle");

        // Asynchronous reset in the middle of a wait
        c_load = 1; c_addr = 32'h500;
        step("t6_acc");
        c_load = 0;
        step("t6_w1");
        c_store = 1;
        #2;
        rst_n = 0;
        #1;
        chk("t6:busy_async", busy, 0);
        chk("t6:m_store_forced", m_store, 0);
        chk("t6:c_ready_forced", c_ready, 0);
        reset_model();
        @(posedge clk);
        #2;
        rst_n = 1;
        c_store = 0;
        step("t6_after");
        step("t6_after2");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            c_load    = ($urandom_range(0, 3) == 0);
            c_store   = ($urandom_range(0, 3) == 0);
            dbg_load  = ($urandom_range(0, 4) == 0);
            dbg_store = ($urandom_range(0, 4) == 0);
            c_addr    = $urandom; c_data = $urandom; c_sel = 4'($urandom);
            dbg_addr  = $urandom; dbg_data = $urandom; dbg_sel = 4'($urandom);
            m_ready   = ($urandom_range(0, 3) != 0);
            m_rvalid  = ($urandom_range(0, 5) == 0);
            m_rdata   = $urandom;
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
